// File: rtl/cv32e40p_obi_pkg.sv
// Shared types and constants for the OBI-to-SRAM bridge and its optional stall generator.
package cv32e40p_obi_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } resp_stage_t;

    localparam logic [31:0] OOR_RDATA = 32'hDEAD_BEEF;

    // x^16 + x^14 + x^13 + x^11 + 1, bit 15 is the x^16 tap
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/cv32e40p_obi_stall_lfsr.sv
// Pseudo-random grant stall source: 16-bit Fibonacci LFSR, stalls when the low two bits are zero.
module cv32e40p_obi_stall_lfsr
    import cv32e40p_obi_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic stall_o
);

    logic [15:0] lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign stall_o = (lfsr[1:0] == 2'b00);

endmodule

// File: rtl/cv32e40p_obi_sram_bridge.sv
// OBI slave to single-port SRAM bridge with fixed-latency in-order responses.
// Define CV32E40P_OBI_STALL_EN to enable pseudo-random grant stalling.
module cv32e40p_obi_sram_bridge
    import cv32e40p_obi_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 16384,
    parameter int unsigned RESP_LATENCY = 1,
    parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic [31:0]                  addr_i,
    input  logic                         we_i,
    input  logic [3:0]                   be_i,
    input  logic [31:0]                  wdata_i,
    output logic                         rvalid_o,
    output logic [31:0]                  rdata_o,
    output logic                         sram_en_o,
    output logic                         sram_we_o,
    output logic [3:0]                   sram_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr_o,
    output logic [31:0]                  sram_wdata_o,
    input  logic [31:0]                  sram_rdata_i,
    output logic                         busy_o,
    output logic [15:0]                  oor_cnt_o
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam int unsigned NSTG = RESP_LATENCY - 1;

    if (RESP_LATENCY < 1 || RESP_LATENCY > 4 || STALL_SEED == 16'h0 ||
        (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_param
        $error("cv32e40p_obi_sram_bridge: illegal parameter value");
    end

    logic stall;

`ifdef CV32E40P_OBI_STALL_EN
    cv32e40p_obi_stall_lfsr #(
        .SEED(STALL_SEED)
    ) u_stall (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .stall_o(stall)
    );
`else
    assign stall = 1'b0;
`endif

    logic        xfer;
    logic        in_range;
    logic [31:0] word_idx;

    assign gnt_o    = req_i && !stall && !rst_i;
    assign xfer     = req_i && gnt_o;
    assign word_idx = addr_i >> 2;
    assign in_range = word_idx < MEM_WORDS;

    assign sram_en_o    = xfer && in_range;
    assign sram_we_o    = sram_en_o && we_i;
    assign sram_be_o    = be_i;
    assign sram_addr_o  = word_idx[AW-1:0];
    assign sram_wdata_o = wdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oor_cnt_o <= '0;
        end else if (xfer && !in_range && oor_cnt_o != 16'hFFFF) begin
            oor_cnt_o <= oor_cnt_o + 16'd1;
        end
    end

    // Transfer attributes held for the cycle in which SRAM read data arrives
    logic a_valid;
    logic a_read;
    logic a_oor;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_valid <= 1'b0;
            a_read  <= 1'b0;
            a_oor   <= 1'b0;
        end else begin
            a_valid <= xfer;
            a_read  <= !we_i;
            a_oor   <= !in_range;
        end
    end

    resp_stage_t cap;

    always_comb begin
        cap.valid = a_valid;
        cap.rdata = '0;
        if (a_valid && a_read) begin
            cap.rdata = a_oor ? OOR_RDATA : sram_rdata_i;
        end
    end

    resp_stage_t             resp;
    logic [RESP_LATENCY-1:0] vbits;

    if (RESP_LATENCY == 1) begin : g_direct
        assign resp  = cap;
        assign vbits = a_valid;
    end else begin : g_pipe
        resp_stage_t [NSTG-1:0] pipe;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipe <= '0;
            end else begin
                pipe[0] <= cap;
                for (int unsigned i = 1; i < NSTG; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign resp = pipe[NSTG-1];

        always_comb begin
            vbits[0] = a_valid;
            for (int unsigned i = 0; i < NSTG; i++) begin
                vbits[i+1] = pipe[i].valid;
            end
        end
    end

    // Gating with reset suppresses a pre-reset response landing in the reset cycle
    assign rvalid_o = resp.valid && !rst_i;
    assign rdata_o  = rvalid_o ? resp.rdata : '0;
    assign busy_o   = |vbits;

endmodule
